// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit:
// state encodings, opcodes, datapath mux encodings and the control word.
package mips_ctrl_pkg;

  localparam int OPC_W = 6;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTYPE  = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    IMMEX  = 4'd9,
    IMMWB  = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [OPC_W-1:0] OP_R    = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPC_W-1:0] OP_ANDI = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OPC_W-1:0] OP_J    = 6'b000010;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       ext_mode;
    logic       illegal_op;
  } ctrl_t;

  // beq takes the branch on equal operands, bne on unequal ones
  function automatic logic branch_taken(input logic [OPC_W-1:0] opcode, input logic zero);
    return ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the controller (master) and the datapath (slave).
interface mips_ctrl_if;
  import mips_ctrl_pkg::*;

  logic [OPC_W-1:0] opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic [1:0]       pc_source;
  logic             ext_mode;
  logic             illegal_op;
  logic [3:0]       state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, ext_mode, illegal_op, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, ext_mode, illegal_op, state_dbg
  );

endinterface

// File: rtl/mips_multicycle_ctrl_outdec.sv
// Control-word decode: maps the current state (plus opcode, zero flag and
// memory handshake where a state needs them) onto the datapath controls.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t           state,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output ctrl_t            ctrl
);

  // Everything defaults to 0; each state raises only what it needs
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
        case (opcode)
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE,
          OP_ADDI, OP_ANDI, OP_ORI, OP_J: ctrl.illegal_op = 1'b0;
          default:                        ctrl.illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      RTYPE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_source     = PCS_ALUOUT;
        ctrl.pc_write_cond = branch_taken(opcode, zero);
      end
      IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        if (opcode == OP_ANDI) begin
          ctrl.alu_op   = ALU_AND;
          ctrl.ext_mode = 1'b1;
        end else if (opcode == OP_ORI) begin
          ctrl.alu_op   = ALU_OR;
          ctrl.ext_mode = 1'b1;
        end else begin
          ctrl.alu_op   = ALU_ADD;
          ctrl.ext_mode = 1'b0;
        end
      end
      IMMWB: begin
        ctrl.reg_write = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS controller: holds the state register and sequencing,
// and forces every output low while reset is asserted.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  mips_ctrl_if.master bus
);

  state_t state;
  ctrl_t  dec_ctrl;
  ctrl_t  ctrl;

  // State register and next-state sequencing in one place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW:             state <= MEMADR;
            OP_R:                     state <= RTYPE;
            OP_BEQ, OP_BNE:           state <= BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI: state <= IMMEX;
            OP_J:                     state <= JUMP;
            default:                  state <= FETCH;
          endcase
        end
        MEMADR: state <= (bus.opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (bus.mem_ready) state <= MEMWB;
        MEMWB:  state <= FETCH;
        MEMWR:  if (bus.mem_ready) state <= FETCH;
        RTYPE:  state <= ALUWB;
        ALUWB:  state <= FETCH;
        BRANCH: state <= FETCH;
        IMMEX:  state <= IMMWB;
        IMMWB:  state <= FETCH;
        JUMP:   state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  mips_ctrl_outdec u_outdec (
    .state     (state),
    .opcode    (bus.opcode),
    .zero      (bus.zero),
    .mem_ready (bus.mem_ready),
    .ctrl      (dec_ctrl)
  );

  // Gate with rst_n so a write in flight is cut the moment reset falls
  always_comb begin
    ctrl = rst_n ? dec_ctrl : '0;
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.ext_mode      = ctrl.ext_mode;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.state_dbg     = rst_n ? state : FETCH;

endmodule
